// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : sdram_port_arbiter_if
// Brief   : Signal bundle between three SDRAM requesters, the port arbiter
//           and the single-port SDRAM test controller.
// Revision: 1.0 - initial release
// ============================================================================
interface sdram_port_arbiter_if #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 16
);
   logic                  p0_req;
   logic                  p0_wr;
   logic [ADDR_WIDTH-1:0] p0_addr;
   logic [DATA_WIDTH-1:0] p0_wdata;
   logic [1:0]            p0_bytesel;
   logic                  p0_ack;

   logic                  p1_req;
   logic                  p1_wr;
   logic [ADDR_WIDTH-1:0] p1_addr;
   logic [DATA_WIDTH-1:0] p1_wdata;
   logic [1:0]            p1_bytesel;
   logic                  p1_ack;

   logic                  p2_req;
   logic                  p2_wr;
   logic [ADDR_WIDTH-1:0] p2_addr;
   logic [DATA_WIDTH-1:0] p2_wdata;
   logic [1:0]            p2_bytesel;
   logic                  p2_ack;

   logic [DATA_WIDTH-1:0] rdata;

   logic                  ctl_req;
   logic                  ctl_wr;
   logic [ADDR_WIDTH-1:0] ctl_addr;
   logic [DATA_WIDTH-1:0] ctl_wdata;
   logic [1:0]            ctl_bytesel;
   logic                  ctl_ack;
   logic [DATA_WIDTH-1:0] ctl_rdata;

   logic [1:0]            grant;
   logic                  busy;

   // Environment side: requesters plus the SDRAM controller response path
   modport master (
      output p0_req, p0_wr, p0_addr, p0_wdata, p0_bytesel,
      output p1_req, p1_wr, p1_addr, p1_wdata, p1_bytesel,
      output p2_req, p2_wr, p2_addr, p2_wdata, p2_bytesel,
      input  p0_ack, p1_ack, p2_ack, rdata,
      input  ctl_req, ctl_wr, ctl_addr, ctl_wdata, ctl_bytesel,
      output ctl_ack, ctl_rdata,
      input  grant, busy
   );

   modport slave (
      input  p0_req, p0_wr, p0_addr, p0_wdata, p0_bytesel,
      input  p1_req, p1_wr, p1_addr, p1_wdata, p1_bytesel,
      input  p2_req, p2_wr, p2_addr, p2_wdata, p2_bytesel,
      output p0_ack, p1_ack, p2_ack, rdata,
      output ctl_req, ctl_wr, ctl_addr, ctl_wdata, ctl_bytesel,
      input  ctl_ack, ctl_rdata,
      output grant, busy
   );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sdram_port_arbiter
// Brief   : Three-port arbiter in front of the SDRAM test controller. Port 0
//           has streak-limited fixed priority; ports 1/2 share round-robin.
// Revision: 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_STREAK = 4
) (
   input  logic                 clk,
   input  logic                 reset_in,
   sdram_port_arbiter_if.slave  bus
);

   localparam logic [3:0] C_MAX_STREAK = 4'(MAX_STREAK);
   localparam logic [1:0] C_NONE       = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic [1:0]            r_grant;
   logic [1:0]            r_rr_last;
   logic [3:0]            r_streak;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  r_ctl_wr;
   logic [ADDR_WIDTH-1:0] r_ctl_addr;
   logic [DATA_WIDTH-1:0] r_ctl_wdata;
   logic [1:0]            r_ctl_bytesel;

   logic [2:0]            w_req;
   logic                  w_others_pending;
   logic                  w_p0_wins;
   logic [1:0]            w_winner;
   logic [3:0]            w_streak_next;
   logic [1:0]            w_rr_next;
   logic                  w_load;
   logic                  w_capture;
   logic [2:0]            w_ack;

   logic                  w_sel_wr;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic [1:0]            w_sel_bytesel;

   assign w_req = {bus.p2_req, bus.p1_req, bus.p0_req};

   // Winner selection: port 0 unless its streak is exhausted while others wait
   always_comb begin
      w_others_pending = w_req[1] | w_req[2];
      w_p0_wins        = w_req[0] && ((r_streak < C_MAX_STREAK) || !w_others_pending);
      w_winner         = C_NONE;
      if (w_p0_wins) begin
         w_winner = 2'd0;
      end else if (r_rr_last == 2'd2) begin
         if (w_req[1]) begin
            w_winner = 2'd1;
         end else if (w_req[2]) begin
            w_winner = 2'd2;
         end
      end else begin
         if (w_req[2]) begin
            w_winner = 2'd2;
         end else if (w_req[1]) begin
            w_winner = 2'd1;
         end
      end
   end

   always_comb begin
      w_streak_next = r_streak;
      w_rr_next     = r_rr_last;
      if (w_winner == 2'd0) begin
         if (!w_others_pending) begin
            w_streak_next = 4'd0;
         end else if (r_streak < C_MAX_STREAK) begin
            w_streak_next = r_streak + 4'd1;
         end
      end else if (w_winner != C_NONE) begin
         w_streak_next = 4'd0;
         w_rr_next     = w_winner;
      end
   end

   always_comb begin
      w_sel_wr      = bus.p0_wr;
      w_sel_addr    = bus.p0_addr;
      w_sel_wdata   = bus.p0_wdata;
      w_sel_bytesel = bus.p0_bytesel;
      case (w_winner)
         2'd1: begin
            w_sel_wr      = bus.p1_wr;
            w_sel_addr    = bus.p1_addr;
            w_sel_wdata   = bus.p1_wdata;
            w_sel_bytesel = bus.p1_bytesel;
         end
         2'd2: begin
            w_sel_wr      = bus.p2_wr;
            w_sel_addr    = bus.p2_addr;
            w_sel_wdata   = bus.p2_wdata;
            w_sel_bytesel = bus.p2_bytesel;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_winner != C_NONE) begin
               w_load       = 1'b1;
               w_state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.ctl_ack) begin
               w_capture    = 1'b1;
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Fields are sampled only on the IDLE->ISSUE transition and held after
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         r_grant       <= C_NONE;
         r_rr_last     <= 2'd2;
         r_streak      <= 4'd0;
         r_rdata       <= '0;
         r_ctl_wr      <= 1'b0;
         r_ctl_addr    <= '0;
         r_ctl_wdata   <= '0;
         r_ctl_bytesel <= 2'b00;
      end else begin
         if (w_load) begin
            r_ctl_wr      <= w_sel_wr;
            r_ctl_addr    <= w_sel_addr;
            r_ctl_wdata   <= w_sel_wdata;
            r_ctl_bytesel <= w_sel_bytesel;
            r_grant       <= w_winner;
            r_streak      <= w_streak_next;
            r_rr_last     <= w_rr_next;
         end
         if (w_capture) begin
            r_rdata <= bus.ctl_rdata;
         end
         if (r_state == ST_DONE) begin
            r_grant <= C_NONE;
         end
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_ack
      assign w_ack[gi] = (r_state == ST_DONE) && (r_grant == 2'(gi));
   end

   assign bus.p0_ack      = w_ack[0];
   assign bus.p1_ack      = w_ack[1];
   assign bus.p2_ack      = w_ack[2];
   assign bus.rdata       = r_rdata;
   assign bus.ctl_req     = (r_state == ST_ISSUE);
   assign bus.ctl_wr      = r_ctl_wr;
   assign bus.ctl_addr    = r_ctl_addr;
   assign bus.ctl_wdata   = r_ctl_wdata;
   assign bus.ctl_bytesel = r_ctl_bytesel;
   assign bus.grant       = r_grant;
   assign bus.busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// Bench for sdram_port_arbiter: single-transaction vector table, scoreboarded
// multi-port streams, and reset / spurious-ack / long-latency corner cases.
module tb_sdram_port_arbiter;
   localparam int AW = 24;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset_in = 1'b0;
   always #5 clk = ~clk;

   sdram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STREAK(4)) dut (
      .clk      (clk),
      .reset_in (reset_in),
      .bus      (bus)
   );

   typedef struct {
      int          port;
      logic        wr;
      logic [23:0] addr;
      logic [15:0] wdata;
      logic [1:0]  bsel;
      int          dly;
      logic [15:0] erd;
      logic [1:0]  egrant;
   } vec_t;

   typedef struct {
      int          port;
      logic [15:0] rdata;
   } exp_t;

   logic [2:0]    req;
   logic [2:0]    wr;
   logic [AW-1:0] addr  [3];
   logic [DW-1:0] wdata [3];
   logic [1:0]    bsel  [3];
   int            left  [3];
   logic [AW-1:0] sbase [3];
   int            kcnt  [3];
   logic [2:0]    acks;

   exp_t sbq[$];
   vec_t vecs[4];
   int   rr_order[6]  = '{1, 2, 1, 2, 1, 2};
   int   stk_order[10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};

   int  errors = 0;
   int  checks = 0;
   int  ack_total = 0;
   int  acks_before = 0;
   int  ack_delay = 1;
   bit  spurious = 1'b0;
   int  ccnt = 0;

   assign bus.p0_req = req[0];  assign bus.p0_wr = wr[0];  assign bus.p0_addr = addr[0];
   assign bus.p0_wdata = wdata[0];  assign bus.p0_bytesel = bsel[0];
   assign bus.p1_req = req[1];  assign bus.p1_wr = wr[1];  assign bus.p1_addr = addr[1];
   assign bus.p1_wdata = wdata[1];  assign bus.p1_bytesel = bsel[1];
   assign bus.p2_req = req[2];  assign bus.p2_wr = wr[2];  assign bus.p2_addr = addr[2];
   assign bus.p2_wdata = wdata[2];  assign bus.p2_bytesel = bsel[2];
   assign acks = {bus.p2_ack, bus.p1_ack, bus.p0_ack};

   function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hBFCC;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // SDRAM controller model: acks ack_delay cycles after ctl_req rises
   initial begin
      bus.ctl_ack   = 1'b0;
      bus.ctl_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.ctl_ack = 1'b0;
         if (spurious) begin
            bus.ctl_ack   = 1'b1;
            bus.ctl_rdata = 16'hDEAD;
            spurious      = 1'b0;
         end else if (bus.ctl_req) begin
            if (ccnt >= ack_delay) begin
               bus.ctl_ack   = 1'b1;
               bus.ctl_rdata = rd_model(bus.ctl_addr);
               ccnt          = 0;
            end else begin
               ccnt++;
            end
         end else begin
            ccnt = 0;
         end
      end
   end

   // Ack monitor: pops the scoreboard, then steps the acked requester
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (acks != 3'b000) begin
            int   p;
            exp_t e;
            ack_total++;
            chk("ack_onehot", 32'($countones(acks)), 32'd1);
            p = acks[0] ? 0 : (acks[1] ? 1 : 2);
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: port %0d acked, expected no ack", p);
            end else begin
               e = sbq.pop_front();
               chk("ack_port", p, e.port);
               chk("ack_rdata", 32'(bus.rdata), 32'(e.rdata));
            end
            if (left[p] > 0) left[p]--;
            if (left[p] == 0) req[p] = 1'b0;
            else addr[p] = addr[p] + 24'd1;
         end
      end
   end

   task automatic run_single(input vec_t v);
      int hi;
      int guard;
      bit hold_ok;
      int p;
      p         = v.port;
      ack_delay = v.dly;
      wr[p]     = v.wr;
      addr[p]   = v.addr;
      wdata[p]  = v.wdata;
      bsel[p]   = v.bsel;
      left[p]   = 1;
      sbq.push_back('{p, v.erd});
      req[p]    = 1'b1;
      tick();
      chk("issue_ctl_req", 32'(bus.ctl_req), 32'd1);
      chk("issue_ctl_addr", 32'(bus.ctl_addr), 32'(v.addr));
      chk("issue_ctl_wr", 32'(bus.ctl_wr), 32'(v.wr));
      chk("issue_ctl_wdata", 32'(bus.ctl_wdata), 32'(v.wdata));
      chk("issue_ctl_bytesel", 32'(bus.ctl_bytesel), 32'(v.bsel));
      chk("issue_grant", 32'(bus.grant), 32'(v.egrant));
      // requester scribbles its fields mid-transaction; ctl_* must not follow
      wdata[p] = ~v.wdata;
      bsel[p]  = ~v.bsel;
      hi = 0; guard = 0; hold_ok = 1'b1;
      while (bus.ctl_req && guard < 1000) begin
         hi++;
         if (bus.ctl_wdata !== v.wdata || bus.ctl_bytesel !== v.bsel ||
             bus.ctl_addr !== v.addr || bus.grant !== v.egrant) hold_ok = 1'b0;
         tick();
         guard++;
      end
      chk("ctl_req_cycles", hi, v.dly + 1);
      chk("fields_held", 32'(hold_ok), 32'd1);
      chk("done_grant", 32'(bus.grant), 32'(v.egrant));
      chk("done_busy", 32'(bus.busy), 32'd1);
      tick();
      chk("idle_grant", 32'(bus.grant), 32'd3);
      chk("idle_busy", 32'(bus.busy), 32'd0);
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n;
      n = 0;
      while ((sbq.size() != 0 || bus.busy || req != 3'b000) && n < bound) begin
         tick();
         n++;
      end
      chk(name, 32'(n < bound), 32'd1);
   endtask

   task automatic stream_port(input int p, input logic [AW-1:0] base, input int n);
      sbase[p] = base;
      addr[p]  = base;
      kcnt[p]  = 0;
      left[p]  = n;
   endtask

   task automatic push_exp(input int p);
      sbq.push_back('{p, rd_model(sbase[p] + AW'(kcnt[p]))});
      kcnt[p]++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit hit, expected the bench to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req = 3'b000;
      wr  = 3'b000;
      for (int i = 0; i < 3; i++) begin
         addr[i] = '0; wdata[i] = '0; bsel[i] = 2'b00; left[i] = 0;
         sbase[i] = '0; kcnt[i] = 0;
      end
      vecs[0] = '{1, 1'b0, 24'h000123, 16'h0000, 2'b11, 5, 16'hBEEF, 2'd1};
      vecs[1] = '{0, 1'b1, 24'hABCDEF, 16'h1234, 2'b10, 2, 16'h7223, 2'd0};
      vecs[2] = '{1, 1'b1, 24'h000000, 16'hFFFF, 2'b01, 1, 16'hBFCC, 2'd1};
      vecs[3] = '{2, 1'b0, 24'hFFFFFF, 16'h0000, 2'b11, 0, 16'h4033, 2'd2};

      reset_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl_req", 32'(bus.ctl_req), 32'd0);
      chk("rst_ctl_wr", 32'(bus.ctl_wr), 32'd0);
      chk("rst_ctl_addr", 32'(bus.ctl_addr), 32'd0);
      chk("rst_ctl_wdata", 32'(bus.ctl_wdata), 32'd0);
      chk("rst_ctl_bytesel", 32'(bus.ctl_bytesel), 32'd0);
      chk("rst_acks", 32'(acks), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      chk("rst_grant", 32'(bus.grant), 32'd3);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      reset_in = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) run_single(vecs[i]);

      // ports 1 and 2 continuous: strict alternation starting with port 1
      wr = 3'b000;
      ack_delay = 1;
      stream_port(1, 24'h100000, 3);
      stream_port(2, 24'h200000, 3);
      for (int i = 0; i < 6; i++) push_exp(rr_order[i]);
      req[1] = 1'b1;
      req[2] = 1'b1;
      wait_drain("rr_drain", 400);

      // port 0 continuous against port 2: four port-0 grants per port-2 grant
      stream_port(0, 24'h300000, 8);
      stream_port(2, 24'h400000, 2);
      for (int i = 0; i < 10; i++) push_exp(stk_order[i]);
      req[0] = 1'b1;
      req[2] = 1'b1;
      wait_drain("streak_drain", 600);

      // reset during ISSUE restores rr_last = 2
      run_single('{1, 1'b0, 24'h000321, 16'h0000, 2'b11, 1, rd_model(24'h000321), 2'd1});
      ack_delay = 20;
      addr[1] = 24'h111111; left[1] = 1;
      addr[2] = 24'h222222; left[2] = 1;
      req[1] = 1'b1;
      req[2] = 1'b1;
      tick();
      chk("rr_prefers_2", 32'(bus.grant), 32'd2);
      repeat (3) tick();
      @(negedge clk);
      reset_in = 1'b0;
      #1;
      chk("rst_mid_ctl_req", 32'(bus.ctl_req), 32'd0);
      chk("rst_mid_acks", 32'(acks), 32'd0);
      chk("rst_mid_grant", 32'(bus.grant), 32'd3);
      @(negedge clk);
      ack_delay = 1;
      sbq.push_back('{1, rd_model(24'h111111)});
      sbq.push_back('{2, rd_model(24'h222222)});
      reset_in = 1'b1;
      tick();
      chk("rst_regrant_p1", 32'(bus.grant), 32'd1);
      wait_drain("rst_drain", 200);

      // spurious ctl_ack while idle
      acks_before = ack_total;
      spurious = 1'b1;
      repeat (4) tick();
      chk("spurious_no_ack", ack_total, acks_before);
      chk("spurious_rdata", 32'(bus.rdata), 32'(rd_model(24'h222222)));
      chk("spurious_grant", 32'(bus.grant), 32'd3);
      chk("spurious_busy", 32'(bus.busy), 32'd0);

      // long controller latency
      acks_before = ack_total;
      run_single('{2, 1'b0, 24'h0A0B0C, 16'h0000, 2'b11, 100, rd_model(24'h0A0B0C), 2'd2});
      repeat (2) tick();
      chk("delayed_ack_once", ack_total - acks_before, 1);

      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
